bus2_arbiter: RTL and testbench



---
 rtl/bus2_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 17 +
 rtl/bus2_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_bus2_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus2_pkg.sv
// bus2_pkg: shared constants and types for the bus2 arbiter.
//   - bus2 geometry (line address width, beat width, line size, beats per line)
//   - C2 command encodings as seen on the shared bus
//   - response watchdog limit
//   - arbiter state enumeration
package bus2_pkg;

  localparam int ADDR2_BUS_SIZE  = 15;
  localparam int DATA_BUS_SIZE   = 16;
  localparam int CACHE_LINE_SIZE = 16;
  localparam int BEATS           = CACHE_LINE_SIZE * 8 / DATA_BUS_SIZE;
  localparam int BEAT_W          = $clog2(BEATS);

  localparam logic [7:0] TIMEOUT_CYCLES = 8'd255;

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_WDATA     = 3'd2,
    ST_TURN      = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_RDATA     = 3'd5,
    ST_DONE      = 3'd6
  } bus2_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin winner select.
//   req_i    : per-requester request
//   ptr_i    : index that has priority this round
//   valid_o  : at least one requester is asking
//   winner_o : first requesting index at or after ptr_i (meaningful when valid_o)
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       valid_o,
  output logic       winner_o
);

  assign valid_o  = |req_i;
  // With only two requesters, "first at or after ptr" is ptr if it asks, else the other one.
  assign winner_o = req_i[ptr_i] ? ptr_i : ~ptr_i;

endmodule

// File: rtl/bus2_arbiter.sv
// bus2_arbiter: owns bus2 on behalf of two line-granularity requesters.
// Picks a requester round-robin, then sequences its whole line transaction
// (command, write beats, response wait, read beats) before releasing the bus.
// A response watchdog aborts a transaction that never gets a C2 response.
//   CLK, RESET          : clock, synchronous active-high reset
//   req, we, addr, wdata: per-requester request, op, line address, write beat
//   grant, wready       : transaction owner, write beat consumed
//   rvalid, rdata       : read beat valid (per requester), shared read data
//   done, err           : completion pulse, aborted-by-timeout qualifier
//   stray_resp          : sticky flag, C2 response seen outside the response wait
//   a2_o, c2_o/c2_oe, d2_o/d2_oe : memory-side drive values and enables
//   c2_i, d2_i          : C2/D2 as seen on the bus
module bus2_arbiter
  import bus2_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [1:0]                  req,
  input  logic [1:0]                  we,
  input  logic [2*ADDR2_BUS_SIZE-1:0] addr,
  input  logic [2*DATA_BUS_SIZE-1:0]  wdata,
  output logic [1:0]                  grant,
  output logic [1:0]                  wready,
  output logic [1:0]                  rvalid,
  output logic [DATA_BUS_SIZE-1:0]    rdata,
  output logic [1:0]                  done,
  output logic [1:0]                  err,
  output logic                        stray_resp,
  output logic [ADDR2_BUS_SIZE-1:0]   a2_o,
  output logic [1:0]                  c2_o,
  output logic                        c2_oe,
  output logic [DATA_BUS_SIZE-1:0]    d2_o,
  output logic                        d2_oe,
  input  logic [1:0]                  c2_i,
  input  logic [DATA_BUS_SIZE-1:0]    d2_i
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  bus2_arb_state_t   state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              ptr_q, ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [7:0]        to_q, to_d;
  logic              err_q, err_d;
  logic              stray_q, stray_d;

  logic              arb_valid;
  logic              arb_winner;
  logic [1:0]        owner_oh;

  logic [ADDR2_BUS_SIZE-1:0] addr_a  [2];
  logic [DATA_BUS_SIZE-1:0]  wdata_a [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign addr_a[gi]  = addr[gi*ADDR2_BUS_SIZE +: ADDR2_BUS_SIZE];
    assign wdata_a[gi] = wdata[gi*DATA_BUS_SIZE +: DATA_BUS_SIZE];
  end

  rr_arbiter2 u_rr (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  assign owner_oh   = owner_q ? 2'b10 : 2'b01;
  assign stray_resp = stray_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      ptr_q   <= 1'b0;
      beat_q  <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      err_q   <= err_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    to_d    = to_q;
    err_d   = err_q;
    // During CMD/WDATA/TURN c2_i echoes our own non-response commands, so any
    // response outside the wait state really comes from someone else.
    stray_d = stray_q | ((c2_i == C2_RESPONSE) && (state_q != ST_WAIT_RESP));

    grant  = 2'b00;
    wready = 2'b00;
    rvalid = 2'b00;
    rdata  = '0;
    done   = 2'b00;
    err    = 2'b00;
    a2_o   = '0;
    c2_o   = C2_NOP;
    c2_oe  = 1'b0;
    d2_o   = '0;
    d2_oe  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_winner;
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        grant  = owner_oh;
        c2_oe  = 1'b1;
        a2_o   = addr_a[owner_q];
        we_d   = we[owner_q];
        err_d  = 1'b0;
        beat_d = '0;
        if (we[owner_q]) begin
          c2_o   = C2_WRITE_LINE;
          d2_oe  = 1'b1;
          d2_o   = wdata_a[owner_q];
          wready = owner_oh;
          beat_d = BEAT_W'(1);
          state_d = ST_WDATA;
        end else begin
          c2_o    = C2_READ_LINE;
          state_d = ST_TURN;
        end
      end

      ST_WDATA: begin
        grant  = owner_oh;
        c2_oe  = 1'b1;
        d2_oe  = 1'b1;
        d2_o   = wdata_a[owner_q];
        wready = owner_oh;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == LAST_BEAT) begin
          to_d    = '0;
          state_d = ST_WAIT_RESP;
        end
      end

      // One NOP cycle so the memory side never sees our C2 drive overlap its response.
      ST_TURN: begin
        grant   = owner_oh;
        c2_oe   = 1'b1;
        to_d    = '0;
        state_d = ST_WAIT_RESP;
      end

      ST_WAIT_RESP: begin
        grant = owner_oh;
        to_d  = to_q + 8'd1;
        if (c2_i == C2_RESPONSE) begin
          if (we_q) begin
            state_d = ST_DONE;
          end else begin
            // Beat 0 of a read arrives together with the response command.
            rvalid  = owner_oh;
            rdata   = d2_i;
            beat_d  = BEAT_W'(1);
            state_d = ST_RDATA;
          end
        end else if (to_q + 8'd1 == TIMEOUT_CYCLES) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_RDATA: begin
        grant  = owner_oh;
        rvalid = owner_oh;
        rdata  = d2_i;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = owner_oh;
        err     = err_q ? owner_oh : 2'b00;
        ptr_d   = ~owner_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus2_arbiter.sv
module tb_bus2_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  req, we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [1:0]  grant, wready, rvalid, done, err;
  logic [15:0] rdata;
  logic        stray_resp;
  logic [14:0] a2_o;
  logic [1:0]  c2_o;
  logic        c2_oe;
  logic [15:0] d2_o;
  logic        d2_oe;
  logic [1:0]  c2_i;
  logic [15:0] d2_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  bus2_arbiter dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .grant      (grant),
    .wready     (wready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .done       (done),
    .err        (err),
    .stray_resp (stray_resp),
    .a2_o       (a2_o),
    .c2_o       (c2_o),
    .c2_oe      (c2_oe),
    .d2_o       (d2_o),
    .d2_oe      (d2_oe),
    .c2_i       (c2_i),
    .d2_i       (d2_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Bounded wait for the next CMD cycle; leaves us at the CMD sample point.
  task automatic wait_grant(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      #1;
      if (grant != 2'b00) break;
    end
    check(tag, grant, exp);
  endtask

  // Completes a read from the TURN cycle onward, response in the first wait cycle.
  task automatic read_xfer(input logic [1:0] g, input logic [15:0] base);
    @(negedge CLK);
    #1;
    check("turn_c2", {grant, c2_oe, c2_o}, {g, 1'b1, 2'd0});
    @(negedge CLK);
    c2_i = 2'd1;
    d2_i = base;
    #1;
    check("rx_beat0", {rvalid, c2_oe, rdata}, {g, 1'b0, base});
    for (int b = 1; b < 8; b++) begin
      @(negedge CLK);
      c2_i = 2'd0;
      d2_i = base + 16'(b);
      #1;
      check("rx_beat", {grant, rvalid, rdata}, {g, g, base + 16'(b)});
    end
    @(negedge CLK);
    d2_i = 16'h0;
    #1;
    check("rx_done", {done, err, grant, rvalid}, {g, 2'b00, 2'b00, 2'b00});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrv;
    int n;

    RESET = 1'b1;
    req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    c2_i = 2'd0; d2_i = 16'h0;
    repeat (3) @(negedge CLK);
    #1;
    check("reset_outs", {grant, wready, rvalid, done, err, stray_resp, c2_oe, d2_oe, c2_o},
          32'h0);
    check("reset_bus", {a2_o, d2_o, rdata}, 32'h0);

    // Read path: requester 0, response 20 cycles after CMD.
    @(negedge CLK);
    RESET = 1'b0;
    req = 2'b01; we = 2'b00; addr[14:0] = 15'h0012;
    #1;
    check("idle_grant", grant, 2'b00);
    nrv = 0;
    for (int cyc = 0; cyc < 28; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) req = 2'b00;
      c2_i = (cyc == 20) ? 2'd1 : 2'd0;
      d2_i = (cyc >= 20) ? 16'h0100 + 16'(cyc - 20) : 16'hDEAD;
      #1;
      if (rvalid == 2'b01) nrv++;
      if (cyc == 0)
        check("rd_cmd", {grant, c2_oe, c2_o, 1'b0, a2_o}, {2'b01, 1'b1, 2'd2, 1'b0, 15'h0012});
      if (cyc == 1) check("rd_turn", {c2_oe, c2_o}, {1'b1, 2'd0});
      if (cyc == 2) check("rd_release", {c2_oe, d2_oe}, 2'b00);
      if (cyc == 19) check("rd_wait_norv", rvalid, 2'b00);
      if (cyc >= 20) check("rd_beat", {rvalid, rdata}, {2'b01, 16'h0100 + 16'(cyc - 20)});
    end
    @(negedge CLK);
    c2_i = 2'd0;
    #1;
    check("rd_done", {done, err, grant, rvalid}, {2'b01, 2'b00, 2'b00, 2'b00});
    check("rd_nbeats", nrv, 8);

    // Write path: requester 1.
    req = 2'b10; we = 2'b10; addr[29:15] = 15'h7FFF; wdata[31:16] = 16'hA000;
    wait_grant("wr_grant", 2'b10);
    check("wr_cmd", {c2_oe, c2_o, d2_oe, wready, 1'b0, a2_o},
          {1'b1, 2'd3, 1'b1, 2'b10, 1'b0, 15'h7FFF});
    check("wr_beat0", d2_o, 16'hA000);
    for (int k = 1; k < 8; k++) begin
      @(negedge CLK);
      if (k == 1) req = 2'b00;
      wdata[31:16] = 16'hA000 + 16'(k);
      #1;
      check("wr_beat", {wready, c2_oe, c2_o, d2_oe, d2_o},
            {2'b10, 1'b1, 2'd0, 1'b1, 16'hA000 + 16'(k)});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      check("wr_wait", {wready, c2_oe, d2_oe, done}, {2'b00, 1'b0, 1'b0, 2'b00});
    end
    @(negedge CLK);
    c2_i = 2'd1;
    #1;
    check("wr_resp_nodone", done, 2'b00);
    @(negedge CLK);
    c2_i = 2'd0;
    #1;
    check("wr_done", {done, err, grant}, {2'b10, 2'b00, 2'b00});

    // Contention: both requesting reads, grants must alternate 0,1,0,1.
    req = 2'b11; we = 2'b00;
    for (int t = 0; t < 4; t++) begin
      wait_grant("rr_grant", (t % 2 == 0) ? 2'b01 : 2'b10);
      read_xfer((t % 2 == 0) ? 2'b01 : 2'b10, 16'h0200 + 16'(t * 16));
    end

    // Timeout: requester 0 read with no response, requester 1 also waiting.
    wait_grant("to_grant", 2'b01);
    @(negedge CLK);
    #1;
    check("to_turn", {c2_oe, c2_o}, {1'b1, 2'd0});
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      #1;
      if (done != 2'b00) break;
      n++;
    end
    check("to_cycles", n, 255);
    check("to_done_err", {done, err}, {2'b01, 2'b01});
    wait_grant("to_next_grant", 2'b10);
    read_xfer(2'b10, 16'h0300);
    req = 2'b00;

    // Reset during beat 3 of a write by requester 0.
    req = 2'b01; we = 2'b01; wdata[15:0] = 16'hB000;
    wait_grant("rst_grant", 2'b01);
    check("rst_beat0", {wready, d2_o}, {2'b01, 16'hB000});
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK);
      wdata[15:0] = 16'hB000 + 16'(k);
      if (k == 3) RESET = 1'b1;
      #1;
      check("rst_wbeat", {wready, d2_o}, {2'b01, 16'hB000 + 16'(k)});
    end
    @(negedge CLK);
    RESET = 1'b0;
    req = 2'b10; we = 2'b00;
    #1;
    check("rst_outs", {grant, wready, rvalid, done, err, stray_resp, c2_oe, d2_oe, c2_o},
          32'h0);
    check("rst_bus", {a2_o, d2_o, rdata}, 32'h0);
    wait_grant("rst_after_grant", 2'b10);
    read_xfer(2'b10, 16'h0400);
    req = 2'b00;

    // Stray response in IDLE.
    @(negedge CLK);
    #1;
    check("stray_clear", stray_resp, 1'b0);
    @(negedge CLK);
    c2_i = 2'd1;
    #1;
    check("stray_norv", {rvalid, done}, 4'b0);
    @(negedge CLK);
    c2_i = 2'd0;
    #1;
    check("stray_set", {stray_resp, rvalid, done}, {1'b1, 4'b0});
    repeat (3) @(negedge CLK);
    #1;
    check("stray_sticky", {stray_resp, grant}, {1'b1, 2'b00});
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("stray_reset", stray_resp, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
